calc_controller: RTL

CALC_CONTROLLER -- requirements
Module: calc_controller

---
 rtl/calc_pkg.sv | 21 ++
 rtl/calc_alu.sv | 50 +++++
 rtl/multiplier_8bit.sv | 15 +
 rtl/calc_controller.sv | 96 +++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the calculator controller: opcodes, FSM states, operand width.
package calc_pkg;

   localparam int unsigned DEFAULT_DATA_W = 8;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_t;

   typedef enum logic [2:0] {
      S_A,
      S_OP,
      S_B,
      S_EXEC,
      S_DONE
   } state_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational arithmetic for calc_controller. Divider only built with CALC_DIV_EN;
// otherwise DIV reports err=1 with a zero result.
module calc_alu
   import calc_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   input  op_t                 op,
   output logic [2*DATA_W-1:0] result,
   output logic                err
);

   logic [2*DATA_W-1:0] a_ext;
   logic [2*DATA_W-1:0] b_ext;
   logic [2*DATA_W-1:0] product;

   assign a_ext = {{DATA_W{1'b0}}, a};
   assign b_ext = {{DATA_W{1'b0}}, b};

   multiplier_8bit u_mul (
      .a (a),
      .b (b),
      .p (product)
   );

   always_comb begin
      result = '0;
      err    = 1'b0;
      case (op)
         OP_ADD: result = a_ext + b_ext;
         OP_SUB: result = a_ext - b_ext;
         OP_MUL: result = product;
         OP_DIV: begin
`ifdef CALC_DIV_EN
            if (b == '0) begin
               err = 1'b1;
            end else begin
               result = {a % b, a / b};
            end
`else
            err = 1'b1;
`endif
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/multiplier_8bit.sv
// Combinational unsigned 8x8 -> 16 shift-and-add multiplier.
module multiplier_8bit (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   always_comb begin
      p = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p + ({8'd0, a} << i);
      end
   end

endmodule

// File: rtl/calc_controller.sv
// Token-driven calculator FSM: captures A, opcode, B, executes in one cycle and
// presents a registered result until consumed. DIV support gated by CALC_DIV_EN.
module calc_controller
   import calc_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   output logic                in_ready,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [2*DATA_W-1:0] result,
   output logic                err
);

   state_t              state;
   logic [DATA_W-1:0]   a_q;
   logic [DATA_W-1:0]   b_q;
   op_t                 op_q;
   logic [2*DATA_W-1:0] alu_result;
   logic                alu_err;
   logic                take;

   assign take = in_valid && in_ready;

   calc_alu #(.DATA_W(DATA_W)) u_alu (
      .a      (a_q),
      .b      (b_q),
      .op     (op_q),
      .result (alu_result),
      .err    (alu_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_A;
         in_ready  <= 1'b1;
         res_valid <= 1'b0;
         result    <= '0;
         err       <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= OP_ADD;
      end else if (clr) begin
         // clr overrides any handshake in the same cycle
         state     <= S_A;
         in_ready  <= 1'b1;
         res_valid <= 1'b0;
      end else begin
         case (state)
            S_A: begin
               if (take) begin
                  a_q   <= in_data;
                  state <= S_OP;
               end
            end
            S_OP: begin
               if (take) begin
                  op_q  <= op_t'(in_data[1:0]);
                  state <= S_B;
               end
            end
            S_B: begin
               if (take) begin
                  b_q      <= in_data;
                  in_ready <= 1'b0;
                  state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               result    <= alu_result;
               err       <= alu_err;
               res_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_A;
               end
            end
            default: begin
               state     <= S_A;
               in_ready  <= 1'b1;
               res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
